jsilicon_alu_seq: RTL and testbench

Parametrised sequential successor to the fixed 8-bit add/sub/mul cells. Accepts one operation per valid/ready handshake and computes add or subtract in one cycle. Multiply uses an iterative shift-add datapath and returns the full double-width product. Results are held on a valid/ready output port. Sits between the instruction decode/register stage and writeback in the JSilicon core.

---
 rtl/jsilicon_alu_pkg.sv | 27 ++
 rtl/jsilicon_alu_iter.sv | 121 ++++++++++++
 rtl/jsilicon_alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_jsilicon_alu_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jsilicon_alu_pkg.sv
// Shared definitions for the JSilicon sequential ALU: op encodings,
// handshake FSM states, iterative-core modes and counter sizing.
// Optional feature macro: JSILICON_ALU_DIV_EN (enables op 11 as unsigned divide).
package jsilicon_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_t;

  // Counter must hold WIDTH-1 for any legal WIDTH
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/jsilicon_alu_iter.sv
// Iterative core: shift-add multiply, and with JSILICON_ALU_DIV_EN a
// restoring shift-subtract divide. Runs exactly WIDTH iterations after start.
// lo/hi present the value after the current iteration; they are the final
// result in the cycle that done is high.
module jsilicon_alu_iter
  import jsilicon_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  iter_mode_t       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;     // accumulator / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;     // multiplier / quotient
  logic [WIDTH-1:0] opnd_q, opnd_d; // multiplicand / divisor
  logic [WIDTH-1:0] hi_nx_c, lo_nx_c;
  logic [WIDTH:0]   mul_sum_c;

  assign mul_sum_c = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

`ifdef JSILICON_ALU_DIV_EN
  iter_mode_t       mode_q, mode_d;
  logic [WIDTH:0]   div_rem_c, div_trial_c;

  // Partial remainder shifted left with the next dividend bit, then trial-subtracted
  assign div_rem_c   = {hi_q, lo_q[WIDTH-1]};
  assign div_trial_c = div_rem_c - {1'b0, opnd_q};
`else
  logic unused_mode_c;
  assign unused_mode_c = mode;
`endif

  // One iteration step of whichever operation is running
  always_comb begin
    hi_nx_c = mul_sum_c[WIDTH:1];
    lo_nx_c = {mul_sum_c[0], lo_q[WIDTH-1:1]};
`ifdef JSILICON_ALU_DIV_EN
    if (mode_q == MODE_DIV) begin
      if (!div_trial_c[WIDTH]) begin
        hi_nx_c = div_trial_c[WIDTH-1:0];
        lo_nx_c = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx_c = div_rem_c[WIDTH-1:0];
        lo_nx_c = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Load on start, otherwise iterate and count down while busy
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
`ifdef JSILICON_ALU_DIV_EN
    mode_d = mode_q;
`endif
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(WIDTH - 1);
      hi_d   = '0;
      lo_d   = a;
      opnd_d = b;
`ifdef JSILICON_ALU_DIV_EN
      mode_d = mode;
`endif
    end else if (busy_q) begin
      hi_d = hi_nx_c;
      lo_d = lo_nx_c;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Datapath and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
`ifdef JSILICON_ALU_DIV_EN
      mode_q <= MODE_MUL;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
`ifdef JSILICON_ALU_DIV_EN
      mode_q <= mode_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '0);
  assign lo   = lo_nx_c;
  assign hi   = hi_nx_c;

endmodule

// File: rtl/jsilicon_alu_seq.sv
// JSilicon sequential ALU: valid/ready front end, single-cycle add/sub,
// iterative multiply (and divide with JSILICON_ALU_DIV_EN), result held
// on a valid/ready output port until taken.
module jsilicon_alu_seq
  import jsilicon_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  alu_state_t       state_q, state_d;
  iter_mode_t       mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic             accept_c;
  logic             start_c;
  iter_mode_t       start_mode_c;
  logic [WIDTH:0]   sum_c, diff_c;
  logic             iter_busy, iter_done;
  logic [WIDTH-1:0] iter_lo, iter_hi;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_c = in_valid && in_ready;
  assign sum_c    = {1'b0, a} + {1'b0, b};
  assign diff_c   = {1'b0, a} - {1'b0, b};

  jsilicon_alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_c),
    .mode  (start_mode_c),
    .a     (a),
    .b     (b),
    .busy  (iter_busy),
    .done  (iter_done),
    .lo    (iter_lo),
    .hi    (iter_hi)
  );

  // Handshake FSM, single-cycle ops and flag generation
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    result_hi_d  = result_hi_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    err_d        = err_q;
    start_c      = 1'b0;
    start_mode_c = MODE_MUL;

    case (state_q)
      BUSY: begin
        if (iter_done) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = iter_lo;
          result_hi_d = iter_hi;
          carry_d     = (mode_q == MODE_MUL) && (iter_hi != '0);
          zero_d      = (iter_lo == '0);
          err_d       = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      IDLE: begin
      end
      default: state_d = IDLE;
    endcase

    // A new request overrides the plain DONE->IDLE release
    if (accept_c) begin
      case (op)
        OP_ADD: begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = sum_c[WIDTH-1:0];
          result_hi_d = '0;
          carry_d     = sum_c[WIDTH];
          zero_d      = (sum_c[WIDTH-1:0] == '0);
          err_d       = 1'b0;
        end
        OP_SUB: begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = diff_c[WIDTH-1:0];
          result_hi_d = '0;
          carry_d     = diff_c[WIDTH];
          zero_d      = (diff_c[WIDTH-1:0] == '0);
          err_d       = 1'b0;
        end
        OP_MUL: begin
          state_d      = BUSY;
          out_valid_d  = 1'b0;
          start_c      = 1'b1;
          start_mode_c = MODE_MUL;
          mode_d       = MODE_MUL;
        end
        default: begin
`ifdef JSILICON_ALU_DIV_EN
          if (b == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = '1;
            result_hi_d = a;
            carry_d     = 1'b0;
            zero_d      = 1'b0;
            err_d       = 1'b1;
          end else begin
            state_d      = BUSY;
            out_valid_d  = 1'b0;
            start_c      = 1'b1;
            start_mode_c = MODE_DIV;
            mode_d       = MODE_DIV;
          end
`else
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = '0;
          result_hi_d = '0;
          carry_d     = 1'b0;
          zero_d      = 1'b1;
          err_d       = 1'b1;
`endif
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= MODE_MUL;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  // The iterative core runs exactly while the FSM sits in BUSY
  a_busy_track : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == BUSY) == iter_busy);

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jsilicon_alu_seq.sv
// Bench for jsilicon_alu_seq (WIDTH=8): directed cases with literal
// expectations plus randomized traffic against a transaction-level model.
// Honours JSILICON_ALU_DIV_EN the same way as the design.
module tb_jsilicon_alu_seq;

  localparam int unsigned W = 8;
  localparam longint unsigned MOD = longint'(1) << W;
`ifdef JSILICON_ALU_DIV_EN
  localparam int DIV_LAT = W + 1;
`else
  localparam int DIV_LAT = 1;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         carry;
    logic         zero;
    logic         err;
    int           lat;
  } exp_t;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   op;
  logic [W-1:0] a, b, result, result_hi;
  logic         carry, zero, err;

  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  bit   have_op = 0;
  int   avail = 0;
  exp_t exp_r;

  jsilicon_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (step %0d)", name, got, want, k);
    end
  endtask

  // What the ALU must return for one request, from the arithmetic definition
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint unsigned xa, yb, r;
    xa = longint'(x);
    yb = longint'(y);
    e.res = '0; e.hi = '0; e.carry = 1'b0; e.err = 1'b0; e.lat = 1;
    case (o)
      2'b00: begin
        r = xa + yb;
        e.res = W'(r % MOD);
        e.carry = (r >= MOD);
      end
      2'b01: begin
        e.res = W'((xa + MOD - yb) % MOD);
        e.carry = (xa < yb);
      end
      2'b10: begin
        r = xa * yb;
        e.res = W'(r % MOD);
        e.hi = W'(r / MOD);
        e.carry = ((r / MOD) != 0);
        e.lat = W + 1;
      end
      default: begin
`ifdef JSILICON_ALU_DIV_EN
        if (yb == 0) begin
          e.res = W'(MOD - 1);
          e.hi = x;
          e.err = 1'b1;
        end else begin
          e.res = W'(xa / yb);
          e.hi = W'(xa % yb);
          e.lat = W + 1;
        end
`else
        e.err = 1'b1;
`endif
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // One clock: drive inputs, compare DUT against the model, advance the model
  task automatic cycle(input bit iv, input logic [1:0] o, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input bit ordy);
    bit ev, er;
    @(negedge clk);
    in_valid = iv; op = o; a = ia; b = ib; out_ready = ordy;
    #1;
    ev = have_op && (k >= avail);
    er = !have_op || (ev && ordy);
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, er);
    if (ev) begin
      chk("result", result, exp_r.res);
      chk("result_hi", result_hi, exp_r.hi);
      chk("carry", carry, exp_r.carry);
      chk("zero", zero, exp_r.zero);
      chk("err", err, exp_r.err);
    end
    if (ev && ordy) have_op = 0;
    if (iv && er) begin
      exp_r = model(o, ia, ib);
      have_op = 1;
      avail = k + exp_r.lat;
    end
    k++;
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_result_hi", result_hi, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    chk("rst_err", err, 0);
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    have_op = 0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; out_ready = 1'b0;
    pulse_reset(2);

    // add with carry out
    cycle(1, 2'b00, 8'hF0, 8'h20, 1);
    cycle(0, 2'b00, 8'h00, 8'h00, 1);
    chk("add_result", result, 8'h10);
    chk("add_carry", carry, 1);
    chk("add_zero", zero, 0);
    chk("add_hi", result_hi, 0);

    // back-to-back subtracts, one result per cycle
    cycle(1, 2'b01, 8'h05, 8'h05, 1);
    cycle(1, 2'b01, 8'h03, 8'h04, 1);
    chk("sub0_result", result, 8'h00);
    chk("sub0_zero", zero, 1);
    chk("sub0_carry", carry, 0);
    chk("sub0_in_ready", in_ready, 1);
    cycle(0, 2'b00, 8'h00, 8'h00, 1);
    chk("sub1_result", result, 8'hFF);
    chk("sub1_carry", carry, 1);

    // multiply latency and full product
    cycle(1, 2'b10, 8'hFF, 8'hFF, 1);
    for (int i = 0; i < W; i++) begin
      cycle(0, 2'b00, 8'h00, 8'h00, 1);
      chk("mul_busy_valid", out_valid, 0);
      chk("mul_busy_ready", in_ready, 0);
    end
    cycle(0, 2'b00, 8'h00, 8'h00, 1);
    chk("mul_valid", out_valid, 1);
    chk("mul_product", {result_hi, result}, 16'hFE01);
    chk("mul_carry", carry, 1);

    // backpressure holds the result
    cycle(1, 2'b00, 8'h01, 8'h02, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 2'b01, 8'h77, 8'h11, 0);
      chk("bp_result", result, 8'h03);
      chk("bp_in_ready", in_ready, 0);
    end
    cycle(0, 2'b00, 8'h00, 8'h00, 1);
    cycle(0, 2'b00, 8'h00, 8'h00, 1);
    chk("bp_released", out_valid, 0);

    // reset in the middle of a multiply
    cycle(1, 2'b10, 8'h12, 8'h34, 1);
    repeat (3) cycle(0, 2'b00, 8'h00, 8'h00, 1);
    pulse_reset(2);
    repeat (W + 3) cycle(0, 2'b00, 8'h00, 8'h00, 1);
    cycle(1, 2'b00, 8'h01, 8'h01, 1);
    cycle(0, 2'b00, 8'h00, 8'h00, 1);
    chk("post_rst_add", result, 8'h02);

    // op 11: divide or reserved
    cycle(1, 2'b11, 8'd100, 8'd7, 1);
    for (int i = 0; i < DIV_LAT; i++) cycle(0, 2'b00, 8'h00, 8'h00, 1);
`ifdef JSILICON_ALU_DIV_EN
    chk("div_quot", result, 8'd14);
    chk("div_rem", result_hi, 8'd2);
    chk("div_err", err, 0);
`else
    chk("rsv_result", result, 8'd0);
    chk("rsv_err", err, 1);
`endif
    cycle(1, 2'b11, 8'd100, 8'd0, 1);
    cycle(0, 2'b00, 8'h00, 8'h00, 1);
`ifdef JSILICON_ALU_DIV_EN
    chk("div0_result", result, 8'hFF);
    chk("div0_hi", result_hi, 8'd100);
`else
    chk("rsv0_result", result, 8'd0);
`endif
    chk("op11_b0_err", err, 1);

    // randomized traffic, occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset(1 + $urandom_range(0, 2));
      end else begin
        cycle($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), rnd_val(), rnd_val(),
              $urandom_range(0, 9) < 7);
      end
    end
    repeat (W + 3) cycle(0, 2'b00, 8'h00, 8'h00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
